rr_mux_arbiter_4: RTL

Round-robin arbiter that shares one 4:1 data mux between four valid/ready requesters and drives a single registered output channel.
- Grants whole packets: a channel keeps the grant until it has transferred a beat with in_last=1.
- Sits in front of any single-consumer resource (bus, FIFO, serializer) and generates the mux select.
- One registered output stage, so latency is one cycle and throughput is one beat per cycle.

---
 rtl/rr_mux_arbiter_4_pkg.sv | 13 +
 rtl/rr_pick_4.sv | 34 +++
 rtl/rr_mux_arbiter_4.sv | 109 ++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_4_pkg.sv
// Shared types and constants for the 4-channel round-robin packet arbiter.
package rr_mux_arb_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Rotating priority picker: finds the first set request at or after ptr,
// wrapping modulo 4. Purely combinational.
module rr_pick_4
  import rr_mux_arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output logic            found,
  output sel_t            idx
);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  sel_t              offset;

  // Doubling the vector lets a plain part-select do the rotation:
  // req_rot[k] == req[(ptr + k) mod 4].
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_CH];

  // Priority-encode the rotated vector (lowest offset wins), then un-rotate.
  always_comb begin
    found  = |req_rot;
    offset = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = sel_t'(k);
      end
    end
  end

  assign idx = ptr + offset;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin packet arbiter sharing a 4:1 data mux between four
// valid/ready requesters, feeding one registered output stage.
module rr_mux_arbiter_4
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH-1:0]      in_last,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]      in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output sel_t                 out_sel,
  output logic                 busy
);

  state_t           state_reg;
  sel_t             ptr_reg;
  sel_t             lock_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_last_reg;
  sel_t             out_sel_reg;

  logic             load;
  logic             found;
  logic             accept;
  sel_t             pick_idx;
  sel_t             grant;
  logic [WIDTH-1:0] ch_data [N_CH];

  // Unpack the flat data bus into one word per channel.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The output register can take a new beat when empty or draining now.
  assign load = !out_valid_reg || out_ready;

  rr_pick_4 u_pick (
    .req   (in_valid),
    .ptr   (ptr_reg),
    .found (found),
    .idx   (pick_idx)
  );

  // Grant selection: locked channel exclusively, else round-robin pick.
  always_comb begin
    in_ready = '0;
    grant    = pick_idx;
    if (state_reg == LOCKED) begin
      grant              = lock_reg;
      in_ready[lock_reg] = load;
    end else if (found && load) begin
      in_ready[pick_idx] = 1'b1;
    end
  end

  assign accept = |(in_valid & in_ready);

  // FSM, rr pointer, lock index and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      lock_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_sel_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= ch_data[grant];
      out_last_reg  <= in_last[grant];
      out_sel_reg   <= grant;
      case (state_reg)
        IDLE: begin
          ptr_reg <= grant + 2'd1;
          if (!in_last[grant]) begin
            state_reg <= LOCKED;
            lock_reg  <= grant;
          end
        end
        LOCKED: begin
          if (in_last[grant]) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end else if (load) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_sel   = out_sel_reg;
  assign busy      = (state_reg == LOCKED);

endmodule
